// File: rtl/pld_bus_pkg.sv
// Shared types and constants for the PLD register bus initiator.
// Holds the FSM state encoding, PLD register map and default bus timing.
package pld_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam logic [7:0] REG1_ADDR = 8'hF0;
  localparam logic [7:0] REG2_ADDR = 8'hE0;
  localparam logic [7:0] REG3_ADDR = 8'hC0;

  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 2;
  localparam int DEF_HOLD_CYC   = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pld_bus_master.sv
// PLD register bus initiator: one valid/ready request becomes a setup/strobe/hold bus cycle.
// Build option PLD_BUS_WAIT_EN adds bus_wait_ to stretch the final strobe cycle (255-cycle timeout).
module pld_bus_master
  import pld_bus_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] Addr,
  output logic              CS_,
  output logic              WR_,
  output logic              OE_,
  output logic [DATA_W-1:0] bus_dout,
  output logic              bus_dout_en,
  input  logic [DATA_W-1:0] bus_din
`ifdef PLD_BUS_WAIT_EN
  , input logic             bus_wait_
`endif
);

  localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cs_n_q, cs_n_d;
  logic              wr_n_q, wr_n_d;
  logic              oe_n_q, oe_n_d;
  logic              dout_en_q, dout_en_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              accept;
  logic              strobe_last;
  logic              stretch;
  logic              timeout;

  assign req_ready   = (state_q == IDLE) && !rst;
  assign accept      = req_valid && req_ready;
  assign strobe_last = (state_q == STROBE) && (cnt_q == '0);

`ifdef PLD_BUS_WAIT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;

  // Stretch only the final strobe cycle; give up once 255 extensions are spent.
  assign stretch    = strobe_last && !bus_wait_;
  assign timeout    = stretch && (wait_cnt_q == 8'hFF);
  assign wait_cnt_d = (stretch && !timeout) ? wait_cnt_q + 8'd1 : 8'd0;

  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= 8'd0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`else
  assign stretch = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      rdata_q     <= '0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      dout_en_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      rdata_q     <= rdata_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      oe_n_q      <= oe_n_d;
      dout_en_q   <= dout_en_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!stretch || timeout) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Bus strobes are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    write_d = write_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    if (accept) begin
      write_d = req_write;
      addr_d  = req_addr;
      dout_d  = req_wdata;
    end
    if (strobe_last && !write_q) begin
      if (timeout)      rdata_d = '1;
      else if (!stretch) rdata_d = bus_din;
    end
    cs_n_d      = (state_d == IDLE);
    oe_n_d      = (state_d != STROBE);
    wr_n_d      = (state_d == IDLE) ? 1'b1 : !write_d;
    dout_en_d   = (state_d != IDLE) && write_d;
    rsp_valid_d = (state_d == HOLD) && (cnt_d == '0);
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign Addr        = addr_q;
  assign CS_         = cs_n_q;
  assign WR_         = wr_n_q;
  assign OE_         = oe_n_q;
  assign bus_dout    = dout_q;
  assign bus_dout_en = dout_en_q;

endmodule

// File: doc/pld_bus_master.md
Name: pld_bus_master

Overview:
- Initiator side of the 8-bit PLD register bus. It generates Addr, CS_, WR_ and OE_ strobes, plus write-data drive, toward the PLD decode logic.
- It converts single-beat requests from the local controller (valid/ready) into timed bus cycles: setup, strobe, hold.
- Read data is sampled at the end of the strobe phase and returned on a one-cycle response pulse.
- Sits between the system controller and the PLD that holds Reg1/Reg2/Reg3.

Parameters:
- ADDR_W, 8, bus address width
- DATA_W, 8, bus data width
- SETUP_CYC, 1, cycles CS_ low / Addr valid before OE_ falls; legal range >=1
- STROBE_CYC, 2, cycles OE_ held low; legal range >=1
- HOLD_CYC, 1, cycles CS_ low / Addr held after OE_ rises; legal range >=1

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  target register address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle pulse: transaction complete
- rsp_rdata  out  DATA_W  read data; valid while rsp_valid is high on a read
- Addr  out  ADDR_W  bus address
- CS_  out  1  chip select, active low
- WR_  out  1  0=write cycle, 1=read cycle
- OE_  out  1  output/strobe enable, active low
- bus_dout  out  DATA_W  write data driven to the bus
- bus_dout_en  out  1  tri-state enable for bus_dout
- bus_din  in  DATA_W  read data from the bus

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). Polarity and synchronicity are fixed.
- All bus outputs are registered.
- Reset values: CS_=1, WR_=1, OE_=1, Addr=0, bus_dout=0, bus_dout_en=0, rsp_valid=0, rsp_rdata=0, state=IDLE, phase counter=0.
- req_ready = (state==IDLE) && !rst, combinational. Requests are accepted only on an edge where req_valid && req_ready; req_* are captured on that edge.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE -> SETUP on accept.
  - SETUP -> STROBE after SETUP_CYC cycles.
  - STROBE -> HOLD after STROBE_CYC cycles.
  - HOLD -> IDLE after HOLD_CYC cycles.
- Phase counter: down-counter of width clog2(max(SETUP_CYC, STROBE_CYC, HOLD_CYC)+1). It is loaded on each state entry.
- Outputs by state:
  - SETUP: CS_=0; Addr=captured address; WR_=!write; OE_=1; bus_dout_en=write.
  - STROBE: OE_=0; other outputs as in SETUP.
  - HOLD: OE_=1; CS_, Addr, WR_ and bus_dout_en unchanged.
  - IDLE: CS_=1, WR_=1, OE_=1, bus_dout_en=0. Addr keeps its last value.
- Timing from accept edge E0: cycles 1..S are SETUP, S+1..S+P are STROBE, S+P+1..S+P+H are HOLD. Here S=SETUP_CYC, P=STROBE_CYC, H=HOLD_CYC.
- rsp_valid is high during the last HOLD cycle only. It is followed by at least one IDLE cycle with CS_=1, so the minimum back-to-back period is S+P+H+1 cycles.
- Reads: bus_din is registered into rsp_rdata on the edge ending the last STROBE cycle. rsp_rdata holds its value until the next read capture; writes do not alter it.
- WR_ is never changed while OE_=0. bus_dout_en never changes while OE_=0.
- req_valid during a busy cycle is ignored (req_ready=0); no queueing.
- rst during any state: on the next edge all outputs return to their reset values. The aborted transaction produces no rsp_valid.
- Illegal address values are not checked. Any 8-bit address is driven as given.

Optional Feature:
- Macro: PLD_BUS_WAIT_EN.
- Defined: adds input port bus_wait_ (1 bit, active low).
  - While in STROBE with the counter at its final cycle and bus_wait_=0, the block stays in STROBE with OE_ low.
  - rdata is captured on the edge where bus_wait_=1 in that final cycle.
  - A wait counter of 8 bits aborts after 255 extension cycles, moving to HOLD and setting rsp_rdata to all 1s.
- Not defined: no port and no wait logic; STROBE lasts exactly STROBE_CYC cycles.

Decomposition:
- Package pld_bus_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD)
  - register address constants REG1_ADDR=8'hF0, REG2_ADDR=8'hE0, REG3_ADDR=8'hC0
  - default timing constants
- No sub-module; the FSM and phase counter are in a single module.

Test Plan:
- Defaults, write 0x5A to 0xF0 -> CS_ low cycles 1-4, OE_ low cycles 2-3, WR_=0 cycles 1-4, bus_dout=0x5A with bus_dout_en=1 cycles 1-4, rsp_valid at cycle 4, req_ready high again at cycle 5.
- Defaults, read 0xE0 with bus_din=0xA5 during STROBE -> WR_=1 throughout, bus_dout_en=0, rsp_rdata=0xA5 at rsp_valid (cycle 4).
- req_valid held high for 3 back-to-back writes to 0xF0/0xE0/0xC0 -> accepts 5 cycles apart; CS_ high for exactly 1 cycle between transactions.
- rst asserted in STROBE of a read -> next edge CS_=OE_=WR_=1; no rsp_valid; rsp_rdata unchanged/0; req_ready=1 after rst drops.
- SETUP_CYC=2, STROBE_CYC=3, HOLD_CYC=2 -> OE_ low cycles 3-5, rsp_valid at cycle 7.
- PLD_BUS_WAIT_EN defined, bus_wait_=0 for 4 extra cycles on a read -> OE_ low 6 cycles total; data captured when bus_wait_=1; rsp_valid 4 cycles later than nominal.
